// File: rtl/sobel_pixel_unpacker.sv
// Sobel ISE pixel unpacker: 16-byte circular FIFO that unpacks pushed words into window-register layouts.
// Optional build macro UNPACKER_STATS_EN adds a saturating rejected-command counter reported by STATUS.
`timescale 1ns/1ps
module sobel_pixel_unpacker #(
   parameter logic [7:0] customInstructionId = 8'd24
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  iseId,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   typedef enum logic [1:0] {OP_PUSH = 2'd0, OP_POP_B = 2'd1, OP_POP_C = 2'd2, OP_STATUS = 2'd3} op_t;

   state_t      state;
   op_t         op;
   op_t         cmd;
   logic [7:0]  mem [0:15];
   logic [3:0]  wr_ptr;
   logic [3:0]  rd_ptr;
   logic [4:0]  count;
   logic [2:0]  left;
   logic [31:0] push_data;
   logic [15:0] pop_data;
   logic [7:0]  stats;
   logic [7:0]  rd_byte;
   logic [7:0]  wr_byte;
   logic [1:0]  idx;
   logic [2:0]  cmd_len;
   logic [2:0]  op_len;
   logic        hit;
   logic        reject;
   logic        unused_bits;

   function automatic logic [2:0] len_of(input op_t o);
      case (o)
         OP_PUSH:  len_of = 3'd4;
         OP_POP_B: len_of = 3'd2;
         OP_POP_C: len_of = 3'd3;
         default:  len_of = 3'd0;
      endcase
   endfunction

   assign unused_bits = ^valueA[31:2];

   always_comb begin
      cmd     = op_t'(valueA[1:0]);
      cmd_len = len_of(cmd);
      op_len  = len_of(op);
      hit     = start && (iseId == customInstructionId) && (state == IDLE);
      reject  = ((cmd == OP_PUSH)  && (count > 5'd12)) ||
                ((cmd == OP_POP_B) && (count < 5'd2))  ||
                ((cmd == OP_POP_C) && (count < 5'd3));
      // byte position within the current command, counting up as left counts down
      idx     = 2'(op_len - left);
      rd_byte = mem[rd_ptr];
      wr_byte = push_data[8*idx +: 8];
   end

   always_ff @(posedge clock) begin
      if (state == XFER && op == OP_PUSH)
         mem[wr_ptr] <= wr_byte;
   end

`ifdef UNPACKER_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stats <= '0;
      else if (hit && reject && stats != '1)
         stats <= stats + 8'd1;
      else if (hit && cmd == OP_STATUS && valueB[0])
         stats <= '0;
   end
`else
   assign stats = '0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         op        <= OP_PUSH;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         left      <= '0;
         push_data <= '0;
         pop_data  <= '0;
         done      <= 1'b0;
         result    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  op        <= cmd;
                  push_data <= valueB;
                  if (reject) begin
                     result <= '1;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else if (cmd == OP_STATUS) begin
                     result <= {stats, 19'd0, count};
                     done   <= 1'b1;
                     state  <= DONE;
                     if (valueB[0]) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        count  <= '0;
                     end
                  end else begin
                     left  <= cmd_len;
                     state <= XFER;
                  end
               end
            end
            XFER: begin
               left <= left - 3'd1;
               if (op == OP_PUSH) begin
                  wr_ptr <= wr_ptr + 4'd1;
                  count  <= count + 5'd1;
               end else begin
                  rd_ptr <= rd_ptr + 4'd1;
                  count  <= count - 5'd1;
                  if (idx == 2'd0) pop_data[7:0]  <= rd_byte;
                  if (idx == 2'd1) pop_data[15:8] <= rd_byte;
               end
               // last byte is folded into the result directly from the FIFO read port
               if (left == 3'd1) begin
                  state <= DONE;
                  done  <= 1'b1;
                  case (op)
                     OP_PUSH:  result <= {27'd0, count + 5'd1};
                     OP_POP_B: result <= {8'h00, rd_byte, 8'h00, pop_data[7:0]};
                     default:  result <= {8'h00, rd_byte, pop_data[15:8], pop_data[7:0]};
                  endcase
               end
            end
            default: begin
               done   <= 1'b0;
               result <= '0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sobel_pixel_unpacker.md
# sobel_pixel_unpacker

Custom-instruction block for the Sobel path that does the reverse of the pixel packer: the CPU pushes packed 32-bit words of four 8-bit grey pixels, and the block returns them in the zero-padded window-register layouts the Sobel core consumes. Pixels are held in a 16-byte circular FIFO and moved one byte per cycle under a small FSM. The block sits on the CPU custom-instruction interface beside the other Sobel ISE blocks.

## Interface
Parameters:
- customInstructionId, 8'd24, instruction ID this block answers to.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  custom-instruction start strobe, one cycle.
- iseId  in  8  instruction ID; the block acts only when it equals customInstructionId while start=1.
- valueA  in  32  command: bits [1:0] = opcode, other bits ignored.
- valueB  in  32  operand: packed pixels {P3,P2,P1,P0} for PUSH; bit 0 = flush for STATUS.
- done  out  1  one-cycle completion pulse.
- result  out  32  result word, valid only while done=1, 32'd0 otherwise.

## Operation
- Storage: 16x8 byte FIFO, 4-bit write and read pointers that wrap 15->0, 5-bit count 0..16.
- Opcodes, with N = bytes moved:
  - 00 PUSH, N=4: write P0, P1, P2, P3 in that order. Needs count <= 12. Result = {27'd0, new count}.
  - 01 POP_B, N=2: read Pa then Pb. Needs count >= 2. Result = {8'h00, Pb, 8'h00, Pa}.
  - 10 POP_C, N=3: read Pa, Pb, Pc. Needs count >= 3. Result = {8'h00, Pc, Pb, Pa}.
  - 11 STATUS, N=0: if valueB[0]=1, pointers and count go to 0. Result = {8'h00 or stats, 19'd0, count before flush}.
- FSM states: IDLE, XFER, DONE.
  - IDLE -> XFER on an accepted start with N>0.
  - IDLE -> DONE on STATUS, or on a rejected command.
  - XFER: one byte per cycle with a down-counter; -> DONE after the Nth byte.
  - DONE: asserts done and result for one cycle, then -> IDLE.
- Rejected command (PUSH with count > 12, POP_B with count < 2, POP_C with count < 3): FIFO unchanged, result = 32'hFFFF_FFFF.
- Starts are honoured only in IDLE. A start in XFER or DONE is ignored; the CPU stalls, so this is illegal but harmless.
- Count changes by 1 per transferred byte. It never exceeds 16 or drops below 0; the rejection rules guarantee this.

## Timing
- Reset (async assert, sync-safe release):
  - FSM = IDLE, pointers = 0, count = 0, down-counter = 0.
  - Result register = 0, done = 0, stats counter = 0.
- Latency from the start cycle to done high:
  - PUSH: 5 cycles.
  - POP_B: 3 cycles.
  - POP_C: 4 cycles.
  - STATUS or rejected command: 1 cycle.
- done stays high for exactly one cycle. result is registered and stable during that cycle, and 0 in every other cycle.
- If reset_n asserts mid-XFER, the transfer is aborted and the FIFO is emptied. No done pulse is issued for the aborted command.
- Pointer wrap is seamless: a PUSH with the write pointer at 14 writes addresses 14, 15, 0, 1.

## Configuration
- UNPACKER_STATS_EN defined:
  - An 8-bit saturating counter increments on every rejected command.
  - STATUS returns the counter in result[31:24].
  - STATUS with valueB[0]=1 also clears the counter.
- Not defined:
  - No counter logic is built.
  - STATUS result[31:24] = 8'h00.

## Test plan
- Reset, then PUSH 32'h44332211 -> done 5 cycles after start, result 32'd4. Then POP_B -> result 32'h00220011. Then STATUS -> result 32'd2.
- PUSH 32'hDDCCBBAA, then POP_C -> result 32'h00CCBBAA and count 1. Then POP_C -> result 32'hFFFFFFFF after 1 cycle, count still 1.
- Wrap: 4 PUSH + 3 POP_C + 2 PUSH brings the pointers past 15. POP_B and POP_C must then return bytes in push order.
- Full: push 16 bytes, then PUSH -> result 32'hFFFFFFFF. With UNPACKER_STATS_EN, STATUS returns 32'h01000010. Without it, STATUS returns 32'h00000010.
- STATUS with valueB=1 on a FIFO of 7 bytes -> result count 7, then STATUS -> 0. A start with iseId=8'd23 causes no done and no state change.
- Assert reset_n low in the 2nd XFER cycle of a PUSH -> no done pulse, result 0. The next STATUS returns count 0.
